// File: rtl/ndp_feed_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ndp_pkg
// Brief    : FSM state encoding and error-cause codes for the NDP feed sequencer
// Revision : 1.0 - initial release
// ============================================================================
package ndp_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FEED     = 3'd1;
  localparam logic [2:0] ST_WAIT_FIN = 3'd2;
  localparam logic [2:0] ST_DRAIN    = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  // Reasons an err pulse can be raised, kept for debug visibility
  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_START_EMPTY = 2'd1;
  localparam logic [1:0] ERR_WR_BLOCKED  = 2'd2;
  localparam logic [1:0] ERR_WR_WAIT_FIN = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ndp_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : ndp_edge_detect
// Brief    : Rising-edge detector for a level input
// Revision : 1.0 - initial release
// ============================================================================
module ndp_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic rise_out
);

  logic level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level_in;
  end

  assign rise_out = level_in & ~level_q;

endmodule
`default_nettype wire

// File: rtl/ndp_feed_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ndp_feed_sequencer
// Brief    : Streams filled scratch-pad layers into the NDP unit, multi-tile
// Revision : 1.0 - initial release
// ============================================================================
module ndp_feed_sequencer
  import ndp_pkg::*;
#(
  parameter int NUM_LAYERS = 32,
  parameter int LAYER_AW   = $clog2(NUM_LAYERS),
  parameter int CNT_W      = $clog2(NUM_LAYERS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_in,
  input  logic                finish_in,
  input  logic                wr_en,
  input  logic [LAYER_AW-1:0] wr_layer,
  input  logic                unit_calc_done,
  output logic [LAYER_AW-1:0] rd_layer,
  output logic                unit_lock,
  output logic                unit_in_done,
  output logic                unit_clr,
  output logic                hready,
  output logic                busy,
  output logic                calc_done_flag,
  output logic                err
);

  localparam logic [CNT_W-1:0]  FILL_MAX = CNT_W'(NUM_LAYERS);
  localparam logic [LAYER_AW:0] LIM_EXT  = (LAYER_AW + 1)'(NUM_LAYERS);

  logic start_e, finish_e;

  ndp_edge_detect u_start_edge (
    .clk      (clk),
    .reset    (reset),
    .level_in (start_in),
    .rise_out (start_e)
  );

  ndp_edge_detect u_finish_edge (
    .clk      (clk),
    .reset    (reset),
    .level_in (finish_in),
    .rise_out (finish_e)
  );

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [LAYER_AW-1:0] rd_layer_q, rd_layer_d;
  logic                lock_q, lock_d;
  logic                in_done_q, in_done_d;
  logic                clr_q, clr_d;
  logic                hready_q, hready_d;
  logic                flag_q, flag_d;
  logic                err_q, err_d;

  logic [LAYER_AW:0]   w_wr_plus1;
  logic [CNT_W-1:0]    w_wr_fill;
  logic                w_host_ok;
  logic                w_launch;

  // Written layer index as a fill count, clamped to the layer capacity
  assign w_wr_plus1 = {1'b0, wr_layer} + (LAYER_AW + 1)'(1);
  assign w_wr_fill  = (w_wr_plus1 > LIM_EXT) ? FILL_MAX : CNT_W'(w_wr_plus1);
  assign w_host_ok  = (state_q == ST_IDLE) || (state_q == ST_DONE);

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    rem_d      = rem_q;
    rd_layer_d = rd_layer_q;
    lock_d     = lock_q;
    in_done_d  = in_done_q;
    clr_d      = 1'b0;
    hready_d   = hready_q;
    flag_d     = flag_q;
    err_d      = 1'b0;
    w_launch   = 1'b0;

    if (wr_en) begin
      if (w_host_ok) begin
        if (w_wr_fill > fill_q) fill_d = w_wr_fill;
      end else if (state_q != ST_WAIT_FIN) begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_e) begin
          if (fill_q == '0) err_d = 1'b1;
          else              w_launch = 1'b1;
        end
      end
      ST_FEED: begin
        if (rem_q == CNT_W'(1)) begin
          lock_d  = 1'b1;
          state_d = ST_WAIT_FIN;
        end else begin
          rd_layer_d = rd_layer_q + LAYER_AW'(1);
          rem_d      = rem_q - CNT_W'(1);
        end
      end
      ST_WAIT_FIN: begin
        if (finish_e) begin
          in_done_d = 1'b1;
          state_d   = ST_DRAIN;
          if (wr_en) err_d = 1'b1;
        end else if (wr_en) begin
          // Host starts a new tile: the write is dropped and must be retried
          err_d    = 1'b1;
          hready_d = 1'b1;
          fill_d   = '0;
          state_d  = ST_IDLE;
        end else if (start_e) begin
          w_launch = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (unit_calc_done) begin
          flag_d   = 1'b1;
          hready_d = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start_e) begin
          clr_d     = 1'b1;
          flag_d    = 1'b0;
          in_done_d = 1'b0;
          if (fill_q == '0) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            w_launch = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_launch) begin
      state_d    = ST_FEED;
      hready_d   = 1'b0;
      rd_layer_d = '0;
      rem_d      = fill_q;
      lock_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fill_q     <= '0;
      rem_q      <= '0;
      rd_layer_q <= '0;
      lock_q     <= 1'b1;
      in_done_q  <= 1'b0;
      clr_q      <= 1'b0;
      hready_q   <= 1'b1;
      flag_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      rem_q      <= rem_d;
      rd_layer_q <= rd_layer_d;
      lock_q     <= lock_d;
      in_done_q  <= in_done_d;
      clr_q      <= clr_d;
      hready_q   <= hready_d;
      flag_q     <= flag_d;
      err_q      <= err_d;
    end
  end

  assign rd_layer       = rd_layer_q;
  assign unit_lock      = lock_q;
  assign unit_in_done   = in_done_q;
  assign unit_clr       = clr_q;
  assign hready         = hready_q;
  assign calc_done_flag = flag_q;
  assign err            = err_q;
  assign busy           = (state_q == ST_FEED) || (state_q == ST_WAIT_FIN) ||
                          (state_q == ST_DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_ndp_feed_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ndp_feed_sequencer
// Brief    : Self-checking bench for ndp_feed_sequencer
// Revision : 1.0 - initial release
// ============================================================================
module tb_ndp_feed_sequencer;

  localparam int N = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_in, finish_in, wr_en, unit_calc_done;
  logic [4:0] wr_layer;
  logic [4:0] rd_layer;
  logic       unit_lock, unit_in_done, unit_clr, hready, busy, calc_done_flag, err;

  always #5 clk = ~clk;

  ndp_feed_sequencer #(.NUM_LAYERS(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_in       (start_in),
    .finish_in      (finish_in),
    .wr_en          (wr_en),
    .wr_layer       (wr_layer),
    .unit_calc_done (unit_calc_done),
    .rd_layer       (rd_layer),
    .unit_lock      (unit_lock),
    .unit_in_done   (unit_in_done),
    .unit_clr       (unit_clr),
    .hready         (hready),
    .busy           (busy),
    .calc_done_flag (calc_done_flag),
    .err            (err)
  );

  int checks   = 0;
  int failures = 0;
  int lock_low_cnt = 0;
  int clr_cnt      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef enum int {M_IDLE, M_FEED, M_WAIT, M_DRAIN, M_DONE} mph_t;
  mph_t m_ph;
  int   m_fill;
  int   m_queue[$];
  bit   m_pst, m_pfin;
  int   e_rd;
  bit   e_lock, e_indone, e_clr, e_hr, e_flag, e_err;

  function automatic void m_reset();
    m_ph = M_IDLE; m_fill = 0; m_queue.delete(); m_pst = 0; m_pfin = 0;
    e_rd = 0; e_lock = 1; e_indone = 0; e_clr = 0; e_hr = 1; e_flag = 0; e_err = 0;
  endfunction

  function automatic void m_start_pass(int f);
    m_queue.delete();
    for (int i = 0; i < f; i++) m_queue.push_back(i);
    e_rd = m_queue.pop_front();
    e_lock = 0; e_hr = 0; m_ph = M_FEED;
  endfunction

  function automatic void m_step(bit st, bit fin, bit wr, int wl, bit cd);
    bit se, fe, host;
    int old_fill, cand;
    se = st & ~m_pst;
    fe = fin & ~m_pfin;
    m_pst = st; m_pfin = fin;
    old_fill = m_fill;
    host = (m_ph == M_IDLE) || (m_ph == M_DONE);
    e_err = 0; e_clr = 0;
    if (wr) begin
      if (host) begin
        cand = (wl + 1 > N) ? N : wl + 1;
        if (cand > m_fill) m_fill = cand;
      end else if (m_ph != M_WAIT) e_err = 1;
    end
    case (m_ph)
      M_IDLE: if (se) begin
        if (old_fill == 0) e_err = 1; else m_start_pass(old_fill);
      end
      M_FEED: begin
        if (m_queue.size() == 0) begin e_lock = 1; m_ph = M_WAIT; end
        else e_rd = m_queue.pop_front();
      end
      M_WAIT: begin
        if (fe) begin
          e_indone = 1; m_ph = M_DRAIN;
          if (wr) e_err = 1;
        end else if (wr) begin
          e_err = 1; e_hr = 1; m_fill = 0; m_ph = M_IDLE;
        end else if (se) m_start_pass(old_fill);
      end
      M_DRAIN: if (cd) begin e_flag = 1; e_hr = 1; m_ph = M_DONE; end
      M_DONE: if (se) begin
        e_clr = 1; e_flag = 0; e_indone = 0;
        if (old_fill == 0) begin e_err = 1; m_ph = M_IDLE; end
        else m_start_pass(old_fill);
      end
      default: ;
    endcase
  endfunction

  function automatic logic [11:0] mk(int rd, bit lk, bit ind, bit cl, bit hr, bit bs, bit fl, bit er);
    logic [4:0] r;
    r = rd[4:0];
    return {r, lk, ind, cl, hr, bs, fl, er};
  endfunction

  function automatic logic [11:0] m_pack();
    bit bs;
    bs = (m_ph == M_FEED) || (m_ph == M_WAIT) || (m_ph == M_DRAIN);
    return mk(e_rd, e_lock, e_indone, e_clr, e_hr, bs, e_flag, e_err);
  endfunction

  function automatic logic [11:0] dut_pack();
    return {rd_layer, unit_lock, unit_in_done, unit_clr, hready, busy, calc_done_flag, err};
  endfunction

  task automatic cyc(input bit st, input bit fin, input bit wr, input int wl, input bit cd);
    start_in = st; finish_in = fin; wr_en = wr; wr_layer = wl[4:0]; unit_calc_done = cd;
    m_step(st, fin, wr, wl, cd);
    @(posedge clk); #1;
    check("model", {20'd0, dut_pack()}, {20'd0, m_pack()});
    if (unit_lock === 1'b0) lock_low_cnt++;
    if (unit_clr === 1'b1) clr_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit st; bit fin; bit wr; int wl; bit cd; logic [11:0] exp;
  } vec_t;
  vec_t tbl[12];

  task automatic set_vec(input int i, input bit st, input int wl, input bit wr, input logic [11:0] e);
    tbl[i].st = st; tbl[i].fin = 0; tbl[i].wr = wr; tbl[i].wl = wl; tbl[i].cd = 0; tbl[i].exp = e;
  endtask

  initial begin
    logic [11:0] v_idle, v_wait;
    v_idle = mk(0, 1, 0, 0, 1, 0, 0, 0);
    v_wait = mk(3, 1, 0, 0, 0, 1, 0, 0);
    set_vec(0, 1, 0, 0, mk(0, 1, 0, 0, 1, 0, 0, 1));
    set_vec(1, 0, 0, 0, v_idle);
    for (int i = 0; i < 4; i++) set_vec(2 + i, 0, i, 1, v_idle);
    set_vec(6, 1, 0, 0, mk(0, 0, 0, 0, 0, 1, 0, 0));
    set_vec(7, 1, 0, 0, mk(1, 0, 0, 0, 0, 1, 0, 0));
    set_vec(8, 0, 0, 0, mk(2, 0, 0, 0, 0, 1, 0, 0));
    set_vec(9, 0, 0, 0, mk(3, 0, 0, 0, 0, 1, 0, 0));
    set_vec(10, 0, 0, 0, v_wait);
    set_vec(11, 0, 0, 0, v_wait);

    reset = 1; start_in = 0; finish_in = 0; wr_en = 0; wr_layer = 0; unit_calc_done = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {20'd0, dut_pack()}, {20'd0, v_idle});
    reset = 0;

    // Start on empty, fill layers 0..3, four-layer feed
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].st, tbl[i].fin, tbl[i].wr, tbl[i].wl, tbl[i].cd);
      check($sformatf("vec%0d", i), {20'd0, dut_pack()}, {20'd0, tbl[i].exp});
    end

    // Write in WAIT_FIN drops the tile fill; new smaller tiles feed their own length
    cyc(0, 0, 1, 7, 0);
    check("waitfin_wr_err", {31'd0, err}, 32'd1);
    check("waitfin_wr_hready", {31'd0, hready}, 32'd1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    lock_low_cnt = 0;
    cyc(1, 0, 0, 0, 0);
    idle(5);
    check("tile2_lock_low", lock_low_cnt, 2);
    cyc(0, 0, 1, 5, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, i, 0);
    lock_low_cnt = 0; clr_cnt = 0;
    cyc(1, 0, 0, 0, 0);
    idle(6);
    check("tile3_lock_low", lock_low_cnt, 3);
    check("tile3_no_clr", clr_cnt, 0);

    // Finish, drain 10 cycles, restart from DONE
    cyc(0, 1, 0, 0, 0);
    check("in_done_set", {31'd0, unit_in_done}, 32'd1);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0);
    check("flag_before_calc", {31'd0, calc_done_flag}, 32'd0);
    cyc(0, 0, 0, 0, 1);
    check("flag_set", {31'd0, calc_done_flag}, 32'd1);
    check("done_not_busy", {31'd0, busy}, 32'd0);
    idle(2);
    check("flag_sticky", {31'd0, calc_done_flag}, 32'd1);
    clr_cnt = 0;
    cyc(1, 0, 0, 0, 0);
    check("clr_pulse", {31'd0, unit_clr}, 32'd1);
    check("flag_cleared", {30'd0, calc_done_flag, unit_in_done}, 32'd0);
    cyc(0, 0, 0, 0, 0);
    check("clr_one_cycle", {31'd0, unit_clr}, 32'd0);
    idle(4);
    check("clr_count", clr_cnt, 1);

    // Finish and write in the same WAIT_FIN cycle
    cyc(0, 1, 1, 9, 0);
    check("fin_wr_err", {31'd0, err}, 32'd1);
    check("fin_wr_drain", {29'd0, busy, unit_in_done, hready}, 32'd6);
    cyc(0, 0, 0, 0, 1);
    lock_low_cnt = 0;
    cyc(1, 0, 0, 0, 0);
    idle(6);
    check("fill_kept", lock_low_cnt, 3);

    // Saturating fill, async reset mid-feed
    cyc(0, 0, 1, 31, 0);
    cyc(0, 0, 1, 31, 0);
    cyc(1, 0, 0, 0, 0);
    idle(5);
    check("sat_feed_rd", {27'd0, rd_layer}, 32'd5);
    start_in = 0; finish_in = 0; wr_en = 0; unit_calc_done = 0;
    reset = 1;
    m_reset();
    #1;
    check("async_reset", {20'd0, dut_pack()}, {20'd0, v_idle});
    @(posedge clk); #1;
    check("reset_hold", {20'd0, dut_pack()}, {20'd0, v_idle});
    reset = 0;
    idle(3);
    check("no_rd_steps", {27'd0, rd_layer}, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        start_in = 0; finish_in = 0; wr_en = 0; unit_calc_done = 0;
        reset = 1;
        m_reset();
        @(posedge clk); #1;
        check("rand_reset", {20'd0, dut_pack()}, {20'd0, m_pack()});
        reset = 0;
      end else begin
        bit st, fin, wr, cd;
        int wl;
        st  = ($urandom_range(0, 9) == 0) ? ~start_in : start_in;
        fin = ($urandom_range(0, 11) == 0) ? ~finish_in : finish_in;
        wr  = ($urandom_range(0, 5) == 0);
        wl  = ($urandom_range(0, 3) == 0) ? 31 : int'($urandom_range(0, 7));
        cd  = ($urandom_range(0, 7) == 0);
        cyc(st, fin, wr, wl, cd);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
